// File: rtl/replacer_pkg.sv
// Shared definitions for the sign-embedding replacer and the sign extractor.
// Holds the default video/count widths, the count and bit-pointer types, the
// pointer reset value, and the packed count-FIFO entry layout.
package replacer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned PTR_W  = $clog2(DATA_W);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    // Pointer starts on the MSB of a fresh byte
    localparam ptr_t PTR_INIT = ptr_t'(DATA_W - 1);

    // One count-FIFO entry: distance to the next position plus its action flags
    typedef struct packed {
        cnt_t cnt;
        logic sign;
        logic ext;
    } cnt_entry_t;

    localparam int unsigned ENTRY_W = $bits(cnt_entry_t);

endpackage

// File: rtl/fifo_prefetch_stage.sv
// Prefetch stage between a 1-cycle-latency FIFO and its consumer.
// Issues a read when the holding register is free (or being consumed), tracks
// the single outstanding read, and captures the returned word with a valid flag.
// The held word can be rewritten in place by the consumer (upd_i).
// Ports:
//   clk, rst          clock, async active-low reset
//   en_i              global enable; all state holds while low
//   empty_i           FIFO empty
//   rd_data_i         FIFO read data, valid the cycle after rd_c_o
//   consume_i         consumer is done with the held word this cycle
//   upd_i, upd_data_i overwrite the held word (word stays valid)
//   rd_c_o            FIFO read strobe (combinational)
//   data_o, valid_o   held word and its valid flag
module fifo_prefetch_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         empty_i,
    input  logic [W-1:0] rd_data_i,
    input  logic         consume_i,
    input  logic         upd_i,
    input  logic [W-1:0] upd_data_i,
    output logic         rd_c_o,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic         run_q;
    logic         pend_q, pend_d;
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // run_q keeps the strobe low while reset is held and on the release cycle
    assign rd_c_o  = run_q & en_i & ~empty_i & ~pend_q & (~valid_q | consume_i);
    assign data_o  = data_q;
    assign valid_o = valid_q;

    // Capture of returned data takes priority over consume/update
    always_comb begin
        pend_d  = pend_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (en_i) begin
            if (consume_i) valid_d = 1'b0;
            if (upd_i)     data_d  = upd_data_i;
            if (pend_q) begin
                data_d  = rd_data_i;
                valid_d = 1'b1;
                pend_d  = 1'b0;
            end
            if (rd_c_o) pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q   <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            run_q   <= 1'b1;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/sign_extractor.sv
// Sign extractor: walks the marked video byte stream using the embedder's
// count/flag entries and writes out the recovered sign bits, one per write.
// Video bytes are consumed and dropped.
// Build option: define EXTEND_CHECK_EN to check extend bits against the
// complement of the last sign bit (sticky ext_err); otherwise ext_err is 0.
// Ports:
//   clk, rst                   clock, async active-low reset
//   clk_en                     global clock enable
//   vid_in, vid_empty, vid_rd  video FIFO (data valid cycle after vid_rd)
//   cnt_in, sign_flag,
//   extend_flag, cnt_empty,
//   cnt_rd                     count FIFO (data valid cycle after cnt_rd)
//   out_afull                  sign output FIFO almost full
//   sign_out, sign_wr          recovered sign bit and its write strobe
//   ext_err                    sticky extend-check mismatch
module sign_extractor
    import replacer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] vid_in,
    input  logic              vid_empty,
    output logic              vid_rd,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              sign_flag,
    input  logic              extend_flag,
    input  logic              cnt_empty,
    output logic              cnt_rd,
    input  logic              out_afull,
    output logic              sign_out,
    output logic              sign_wr,
    output logic              ext_err
);

    logic              module_en;
    logic              step;
    logic              byte_done, entry_done;
    logic              vid_valid, cnt_valid;
    logic [DATA_W-1:0] vid_reg;
    logic [ENTRY_W-1:0] ent_raw;
    cnt_entry_t        ent_in, ent_q, ent_upd;
    logic              ent_upd_en;
    logic              bit_val;

    ptr_t ptr_q, ptr_d;
    logic sign_out_q, sign_out_d;
    logic sign_wr_q, sign_wr_d;
    logic last_sign_q, last_sign_d;

    assign module_en = clk_en & ~out_afull;
    assign step      = vid_valid & cnt_valid & module_en;
    assign ent_in    = '{cnt: cnt_in, sign: sign_flag, ext: extend_flag};
    assign ent_q     = cnt_entry_t'(ent_raw);

    // Video byte prefetch
    fifo_prefetch_stage #(.W(DATA_W)) u_vid_stage (
        .clk        (clk),
        .rst        (rst),
        .en_i       (module_en),
        .empty_i    (vid_empty),
        .rd_data_i  (vid_in),
        .consume_i  (byte_done),
        .upd_i      (1'b0),
        .upd_data_i ('0),
        .rd_c_o     (vid_rd),
        .data_o     (vid_reg),
        .valid_o    (vid_valid)
    );

    // Count entry prefetch; remaining distance is rewritten on byte crossings
    fifo_prefetch_stage #(.W(ENTRY_W)) u_cnt_stage (
        .clk        (clk),
        .rst        (rst),
        .en_i       (module_en),
        .empty_i    (cnt_empty),
        .rd_data_i  (ENTRY_W'(ent_in)),
        .consume_i  (entry_done),
        .upd_i      (ent_upd_en),
        .upd_data_i (ENTRY_W'(ent_upd)),
        .rd_c_o     (cnt_rd),
        .data_o     (ent_raw),
        .valid_o    (cnt_valid)
    );

`ifdef EXTEND_CHECK_EN
    logic ext_err_q, ext_err_d;
`else
    logic unused_ext;
    assign unused_ext = ^{ent_q.ext, last_sign_q};
`endif

    // Step: either act on a bit within the current byte or cross to the next byte
    always_comb begin
        ptr_d       = ptr_q;
        sign_out_d  = sign_out_q;
        sign_wr_d   = 1'b0;
        last_sign_d = last_sign_q;
        byte_done   = 1'b0;
        entry_done  = 1'b0;
        bit_val     = 1'b0;
        ent_upd     = ent_q;
        ent_upd_en  = 1'b0;
`ifdef EXTEND_CHECK_EN
        ext_err_d   = ext_err_q;
`endif
        if (step) begin
            if (ent_q.cnt <= cnt_t'(ptr_q)) begin
                ptr_d      = ptr_q - ptr_t'(ent_q.cnt);
                bit_val    = vid_reg[ptr_d];
                entry_done = 1'b1;
                if (ent_q.sign) begin
                    sign_out_d  = bit_val;
                    sign_wr_d   = 1'b1;
                    last_sign_d = bit_val;
                end
`ifdef EXTEND_CHECK_EN
                // Extend bit must be the complement of the last sign bit
                else if (ent_q.ext && (bit_val == last_sign_q)) begin
                    ext_err_d = 1'b1;
                end
`endif
            end else begin
                // Remaining distance after skipping the rest of this byte
                ent_upd.cnt = ent_q.cnt - (cnt_t'(ptr_q) + cnt_t'(1));
                ent_upd_en  = 1'b1;
                ptr_d       = PTR_INIT;
                byte_done   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= PTR_INIT;
            sign_out_q  <= 1'b0;
            sign_wr_q   <= 1'b0;
            last_sign_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            sign_out_q  <= sign_out_d;
            sign_wr_q   <= sign_wr_d;
            last_sign_q <= last_sign_d;
        end
    end

`ifdef EXTEND_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ext_err_q <= 1'b0;
        else      ext_err_q <= ext_err_d;
    end
    assign ext_err = ext_err_q;
`else
    assign ext_err = 1'b0;
`endif

    assign sign_out = sign_out_q;
    assign sign_wr  = sign_wr_q;

endmodule

// File: tb/tb_sign_extractor.sv
// Directed bench for sign_extractor with behavioural 1-cycle-latency FIFOs.
module tb_sign_extractor;
    import replacer_pkg::*;

`ifdef EXTEND_CHECK_EN
    localparam int EXT_EXP = 1;
`else
    localparam int EXT_EXP = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clk_en = 1'b1;
    logic              out_afull = 1'b0;
    logic [DATA_W-1:0] vid_in = '0;
    logic              vid_empty, vid_rd;
    logic [CNT_W-1:0]  cnt_in = '0;
    logic              sign_flag = 1'b0, extend_flag = 1'b0;
    logic              cnt_empty, cnt_rd;
    logic              sign_out, sign_wr, ext_err;

    sign_extractor dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .vid_in      (vid_in),
        .vid_empty   (vid_empty),
        .vid_rd      (vid_rd),
        .cnt_in      (cnt_in),
        .sign_flag   (sign_flag),
        .extend_flag (extend_flag),
        .cnt_empty   (cnt_empty),
        .cnt_rd      (cnt_rd),
        .out_afull   (out_afull),
        .sign_out    (sign_out),
        .sign_wr     (sign_wr),
        .ext_err     (ext_err)
    );

    always #5 clk = ~clk;

    // FIFO models: pushes from the stimulus, pops on rd strobes, flushed by reset
    logic [DATA_W-1:0]  vid_mem [256];
    logic [CNT_W+1:0]   cnt_mem [256];
    int vid_wr_n = 0, vid_rd_n = 0, cnt_wr_n = 0, cnt_rd_n = 0;

    assign vid_empty = (vid_rd_n == vid_wr_n);
    assign cnt_empty = (cnt_rd_n == cnt_wr_n);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            vid_rd_n <= vid_wr_n;
            cnt_rd_n <= cnt_wr_n;
        end else begin
            if (vid_rd && !vid_empty) begin
                vid_in   <= vid_mem[vid_rd_n % 256];
                vid_rd_n <= vid_rd_n + 1;
            end
            if (cnt_rd && !cnt_empty) begin
                {cnt_in, sign_flag, extend_flag} <= cnt_mem[cnt_rd_n % 256];
                cnt_rd_n <= cnt_rd_n + 1;
            end
        end
    end

    // Write monitor: logs every sign write and counts writes after a disabled cycle
    logic en_last = 1'b1;
    logic wr_log [256];
    int   wr_total = 0, stall_wr = 0;

    always @(posedge clk) en_last <= clk_en & ~out_afull;

    always @(negedge clk) begin
        if (sign_wr) begin
            wr_log[wr_total % 256] <= sign_out;
            wr_total <= wr_total + 1;
            if (!en_last) stall_wr <= stall_wr + 1;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push_vid(input logic [DATA_W-1:0] b);
        vid_mem[vid_wr_n % 256] = b;
        vid_wr_n++;
    endtask

    task automatic push_ent(input int c, input logic s, input logic e);
        cnt_mem[cnt_wr_n % 256] = {CNT_W'(c), s, e};
        cnt_wr_n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clk_en = 1'b1;
        out_afull = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_wr(input int target, input string tag);
        int cyc = 0;
        while (wr_total < target && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        chk(tag, int'(wr_total >= target), 1);
    endtask

    // Four sign entries on byte B4 (bits 7..4 = 1,0,1,1) with a 3-cycle stall
    task automatic run_stall(input logic use_clk_en, input string tag);
        int base, st0;
        do_reset();
        base = wr_total;
        st0  = stall_wr;
        push_vid(8'hB4);
        push_ent(0, 1'b1, 1'b0);
        push_ent(1, 1'b1, 1'b0);
        push_ent(1, 1'b1, 1'b0);
        push_ent(1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        if (use_clk_en) clk_en = 1'b0;
        else            out_afull = 1'b1;
        repeat (3) @(negedge clk);
        clk_en = 1'b1;
        out_afull = 1'b0;
        wait_wr(base + 4, {tag, "_wait"});
        repeat (10) @(negedge clk);
        chk({tag, "_count"}, wr_total - base, 4);
        chk({tag, "_b0"}, int'(wr_log[base % 256]), 1);
        chk({tag, "_b1"}, int'(wr_log[(base + 1) % 256]), 0);
        chk({tag, "_b2"}, int'(wr_log[(base + 2) % 256]), 1);
        chk({tag, "_b3"}, int'(wr_log[(base + 3) % 256]), 1);
        chk({tag, "_wr_in_stall"}, stall_wr - st0, 0);
    endtask

    initial begin
        int base, cyc;

        // Reset state, with data pending in both FIFOs
        repeat (3) @(negedge clk);
        push_vid(8'hFF);
        push_ent(0, 1'b1, 1'b0);
        #1;
        chk("rst_sign_out", int'(sign_out), 0);
        chk("rst_sign_wr",  int'(sign_wr), 0);
        chk("rst_ext_err",  int'(ext_err), 0);
        chk("rst_vid_rd",   int'(vid_rd), 0);
        chk("rst_cnt_rd",   int'(cnt_rd), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // A5,3C: bit7 of A5=1, bit5 of A5=1, P=9 -> bit6 of 3C=0
        base = wr_total;
        push_vid(8'hA5);
        push_vid(8'h3C);
        push_ent(0, 1'b1, 1'b0);
        push_ent(2, 1'b1, 1'b0);
        push_ent(7, 1'b1, 1'b0);
        wait_wr(base + 3, "t1_wait");
        chk("t1_b0", int'(wr_log[base % 256]), 1);
        chk("t1_b1", int'(wr_log[(base + 1) % 256]), 1);
        chk("t1_b2", int'(wr_log[(base + 2) % 256]), 0);

        // cnt=20 over 00,00 lands on bit3 of FF; then cnt=4 crosses to bit7 of 7F
        do_reset();
        base = wr_total;
        push_vid(8'h00);
        push_vid(8'h00);
        push_vid(8'hFF);
        push_vid(8'h7F);
        push_ent(20, 1'b1, 1'b0);
        push_ent(4, 1'b1, 1'b0);
        cyc = 0;
        while (!sign_wr && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t2_latency", cyc, 7);
        chk("t2_bit_ff", int'(sign_out), 1);
        wait_wr(base + 2, "t2_wait");
        chk("t2_bit_7f", int'(wr_log[(base + 1) % 256]), 0);

        // cnt=0 twice on the MSB of 80, then one step to bit6
        do_reset();
        base = wr_total;
        push_vid(8'h80);
        push_ent(0, 1'b1, 1'b0);
        push_ent(0, 1'b1, 1'b0);
        push_ent(1, 1'b1, 1'b0);
        wait_wr(base + 3, "t3_wait");
        chk("t3_b0", int'(wr_log[base % 256]), 1);
        chk("t3_b1", int'(wr_log[(base + 1) % 256]), 1);
        chk("t3_b2", int'(wr_log[(base + 2) % 256]), 0);

        run_stall(1'b0, "t4_afull");
        run_stall(1'b1, "t4_clken");

        // Extend check: complement case first, then a mismatch, then stickiness
        do_reset();
        base = wr_total;
        push_vid(8'h80);
        push_ent(0, 1'b1, 1'b0);
        push_ent(1, 1'b0, 1'b1);
        wait_wr(base + 1, "t5_wait_a");
        repeat (6) @(negedge clk);
        chk("t5_ext_ok", int'(ext_err), 0);
        push_vid(8'hC0);
        push_ent(7, 1'b1, 1'b0);
        push_ent(1, 1'b0, 1'b1);
        wait_wr(base + 2, "t5_wait_b");
        repeat (6) @(negedge clk);
        chk("t5_sign_c0", int'(wr_log[(base + 1) % 256]), 1);
        chk("t5_ext_bad", int'(ext_err), EXT_EXP);
        push_ent(1, 1'b1, 1'b0);
        wait_wr(base + 3, "t5_wait_c");
        chk("t5_bit5_c0", int'(wr_log[(base + 2) % 256]), 0);
        chk("t5_ext_sticky", int'(ext_err), EXT_EXP);

        // Async reset right after a write, with both FIFOs still holding data
        do_reset();
        push_vid(8'hFF);
        push_vid(8'hFF);
        for (int i = 0; i < 8; i++) push_ent(1, 1'b1, 1'b0);
        cyc = 0;
        while (!sign_wr && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_pre_sign_out", int'(sign_out), 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_sign_out", int'(sign_out), 0);
        chk("t6_sign_wr",  int'(sign_wr), 0);
        chk("t6_vid_rd",   int'(vid_rd), 0);
        chk("t6_cnt_rd",   int'(cnt_rd), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        base = wr_total;
        push_vid(8'h40);
        push_ent(1, 1'b1, 1'b0);
        push_ent(6, 1'b1, 1'b0);
        wait_wr(base + 2, "t6_wait");
        chk("t6_fresh_b6", int'(wr_log[base % 256]), 1);
        chk("t6_fresh_b0", int'(wr_log[(base + 1) % 256]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
